// File: rtl/seq_alu.sv
// Sequential ALU: one request at a time over a valid/ready handshake, registered result and flags.
// Define SEQ_ALU_DIV_EN to build the iterative restoring divider (opcode 1000) and its DIV state.
module seq_alu #(
    parameter int IN_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_WIDTH-1:0]     a,
    input  logic [IN_WIDTH-1:0]     b,
    input  logic [3:0]              opcode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*IN_WIDTH-1:0]   result,
    output logic                    a_greater,
    output logic                    a_equal,
    output logic                    a_less,
    output logic                    err
);
    localparam int OUT_WIDTH = 2 * IN_WIDTH;
    localparam logic [OUT_WIDTH-1:0] SHIFT_LIMIT = OUT_WIDTH'(OUT_WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef SEQ_ALU_DIV_EN
        DIV  = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t state, state_next, accept_state;

    logic                 accept;
    logic [OUT_WIDTH-1:0] a_ext, b_ext;
    logic [OUT_WIDTH-1:0] alu_result;
    logic [2:0]           alu_flags;
    logic                 alu_err;

    logic [OUT_WIDTH-1:0] result_q;
    logic [2:0]           flags_q;
    logic                 err_q;

    assign accept = in_valid && in_ready;
    assign a_ext  = {{IN_WIDTH{1'b0}}, a};
    assign b_ext  = {{IN_WIDTH{1'b0}}, b};

`ifdef SEQ_ALU_DIV_EN
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] COUNT_DONE = CNT_W'(IN_WIDTH);

    logic [IN_WIDTH-1:0] quot_q, rem_q, divisor_q;
    logic [CNT_W-1:0]    div_count;
    logic [IN_WIDTH:0]   rem_shift;
    logic [IN_WIDTH-1:0] rem_sub;
    logic                rem_fits;

    // Zero divisors never enter DIV; they complete in one cycle like any other op.
    assign accept_state = (opcode == OP_DIV && b != '0) ? DIV : DONE;

    // One restoring step: shift the next dividend bit in, subtract when the divisor fits.
    assign rem_shift = {rem_q, quot_q[IN_WIDTH-1]};
    assign rem_fits  = rem_shift >= {1'b0, divisor_q};
    assign rem_sub   = rem_shift[IN_WIDTH-1:0] - divisor_q;
`else
    assign accept_state = DONE;
`endif

    always_comb begin
        alu_result = '0;
        alu_flags  = 3'b000;
        alu_err    = 1'b0;
        case (opcode)
            OP_ADD: alu_result = a_ext + b_ext;
            OP_SUB: alu_result = a_ext - b_ext;
            OP_AND: alu_result = a_ext & b_ext;
            OP_OR:  alu_result = a_ext | b_ext;
            OP_XOR: alu_result = a_ext ^ b_ext;
            OP_SHL: alu_result = (b_ext >= SHIFT_LIMIT) ? '0 : (a_ext << b_ext);
            OP_SHR: alu_result = (b_ext >= SHIFT_LIMIT) ? '0 : (a_ext >> b_ext);
            OP_MUL: alu_result = a_ext * b_ext;
            OP_CMP: alu_flags  = {a > b, a == b, a < b};
`ifdef SEQ_ALU_DIV_EN
            // Only the divide-by-zero case is taken from here.
            OP_DIV: begin
                alu_result = {a, {IN_WIDTH{1'b1}}};
                alu_err    = 1'b1;
            end
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = accept_state;
`ifdef SEQ_ALU_DIV_EN
            DIV:  if (div_count == COUNT_DONE) state_next = DONE;
`endif
            DONE: begin
                if (accept)         state_next = accept_state;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || (state == DONE && out_ready);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= '0;
            flags_q   <= 3'b000;
            err_q     <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            div_count <= '0;
`endif
        end else if (accept) begin
`ifdef SEQ_ALU_DIV_EN
            if (accept_state == DIV) begin
                quot_q    <= a;
                rem_q     <= '0;
                divisor_q <= b;
                div_count <= '0;
            end else
`endif
            begin
                result_q <= alu_result;
                flags_q  <= alu_flags;
                err_q    <= alu_err;
            end
        end
`ifdef SEQ_ALU_DIV_EN
        else if (state == DIV) begin
            if (div_count == COUNT_DONE) begin
                result_q <= {rem_q, quot_q};
                flags_q  <= 3'b000;
                err_q    <= 1'b0;
            end else begin
                rem_q     <= rem_fits ? rem_sub : rem_shift[IN_WIDTH-1:0];
                quot_q    <= {quot_q[IN_WIDTH-2:0], rem_fits};
                div_count <= div_count + 1'b1;
            end
        end
`endif
    end

    assign result    = result_q;
    assign a_greater = flags_q[2];
    assign a_equal   = flags_q[1];
    assign a_less    = flags_q[0];
    assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at IN_WIDTH=8; expectations follow SEQ_ALU_DIV_EN.
module tb_seq_alu;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [7:0]  a, b;
    logic [3:0]  opcode;
    logic        out_valid, out_ready;
    logic [15:0] result;
    logic        a_greater, a_equal, a_less, err;

    int errCount = 0;
    int checkCount = 0;

    typedef struct {
        string       name;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  op;
        logic [15:0] expResult;
        logic [2:0]  expFlags;
        logic        expErr;
        int          expLatency;
    } vec_t;

    vec_t vectors[$];

    seq_alu #(.IN_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .a_greater (a_greater),
        .a_equal   (a_equal),
        .a_less    (a_less),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one request, then count cycles from the accepting edge until out_valid shows up.
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vop,
                                 output int latency);
        int waitCycles;
        @(negedge clk);
        a = va; b = vb; opcode = vop; in_valid = 1'b1;
        waitCycles = 0;
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); opcode = 4'($urandom);
        latency = 1;
        while (!out_valid && latency < 50) begin
            @(negedge clk);
            latency++;
        end
    endtask

    initial begin
        int lat;
        bit seen;

        vectors.push_back(vec_t'{"add",        8'd200, 8'd100, OP_ADD, 16'h012C, 3'b000, 1'b0, 1});
        vectors.push_back(vec_t'{"sub wrap",   8'd5,   8'd7,   OP_SUB, 16'hFFFE, 3'b000, 1'b0, 1});
        vectors.push_back(vec_t'{"and",        8'hF0,  8'h3C,  OP_AND, 16'h0030, 3'b000, 1'b0, 1});
        vectors.push_back(vec_t'{"or",         8'hF0,  8'h0F,  OP_OR,  16'h00FF, 3'b000, 1'b0, 1});
        vectors.push_back(vec_t'{"xor",        8'hFF,  8'h0F,  OP_XOR, 16'h00F0, 3'b000, 1'b0, 1});
        vectors.push_back(vec_t'{"shl 4",      8'h81,  8'd4,   OP_SHL, 16'h0810, 3'b000, 1'b0, 1});
        vectors.push_back(vec_t'{"shl 15",     8'h01,  8'd15,  OP_SHL, 16'h8000, 3'b000, 1'b0, 1});
        vectors.push_back(vec_t'{"shl 16",     8'h81,  8'd16,  OP_SHL, 16'h0000, 3'b000, 1'b0, 1});
        vectors.push_back(vec_t'{"shr 4",      8'hF0,  8'd4,   OP_SHR, 16'h000F, 3'b000, 1'b0, 1});
        vectors.push_back(vec_t'{"shr 16",     8'hF0,  8'd16,  OP_SHR, 16'h0000, 3'b000, 1'b0, 1});
        vectors.push_back(vec_t'{"mul max",    8'hFF,  8'hFF,  OP_MUL, 16'hFE01, 3'b000, 1'b0, 1});
        vectors.push_back(vec_t'{"cmp eq",     8'd3,   8'd3,   OP_CMP, 16'h0000, 3'b010, 1'b0, 1});
        vectors.push_back(vec_t'{"cmp gt",     8'd9,   8'd4,   OP_CMP, 16'h0000, 3'b100, 1'b0, 1});
        vectors.push_back(vec_t'{"cmp lt",     8'd4,   8'd9,   OP_CMP, 16'h0000, 3'b001, 1'b0, 1});
        vectors.push_back(vec_t'{"illegal b",  8'd12,  8'd34,  4'b1011, 16'h0000, 3'b000, 1'b1, 1});
        vectors.push_back(vec_t'{"illegal f",  8'd12,  8'd34,  4'b1111, 16'h0000, 3'b000, 1'b1, 1});
`ifdef SEQ_ALU_DIV_EN
        vectors.push_back(vec_t'{"div 200/7",  8'd200, 8'd7,   OP_DIV, 16'h041C, 3'b000, 1'b0, 9});
        vectors.push_back(vec_t'{"div 13/0",   8'd13,  8'd0,   OP_DIV, 16'h0DFF, 3'b000, 1'b1, 1});
        vectors.push_back(vec_t'{"div 255/1",  8'd255, 8'd1,   OP_DIV, 16'h00FF, 3'b000, 1'b0, 9});
        vectors.push_back(vec_t'{"div 7/200",  8'd7,   8'd200, OP_DIV, 16'h0700, 3'b000, 1'b0, 9});
`else
        vectors.push_back(vec_t'{"div off",    8'd200, 8'd7,   OP_DIV, 16'h0000, 3'b000, 1'b1, 1});
        vectors.push_back(vec_t'{"div off b0", 8'd13,  8'd0,   OP_DIV, 16'h0000, 3'b000, 1'b1, 1});
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; opcode = '0;
        #12;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset result", result, 0);
        checkOutput("reset flags", {a_greater, a_equal, a_less}, 0);
        checkOutput("reset err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].op, lat);
            checkOutput($sformatf("%s latency", vectors[i].name), lat, vectors[i].expLatency);
            checkOutput($sformatf("%s result", vectors[i].name), result, vectors[i].expResult);
            checkOutput($sformatf("%s flags", vectors[i].name), {a_greater, a_equal, a_less}, vectors[i].expFlags);
            checkOutput($sformatf("%s err", vectors[i].name), err, vectors[i].expErr);
            @(negedge clk);
            checkOutput($sformatf("%s drop", vectors[i].name), out_valid, 0);
        end

        // Backpressure: result held for five stalled cycles, then back-to-back accept.
        out_ready = 1'b0;
        applyStimulus(8'd3, 8'd3, OP_CMP, lat);
        checkOutput("stall latency", lat, 1);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("stall%0d out_valid", c), out_valid, 1);
            checkOutput($sformatf("stall%0d a_equal", c), a_equal, 1);
            checkOutput($sformatf("stall%0d result", c), result, 0);
            checkOutput($sformatf("stall%0d in_ready", c), in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        a = 8'd10; b = 8'd20; opcode = OP_ADD; in_valid = 1'b1;
        #1;
        checkOutput("b2b in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("b2b out_valid", out_valid, 1);
        checkOutput("b2b result", result, 16'd30);
        checkOutput("b2b flags", {a_greater, a_equal, a_less}, 0);
        @(negedge clk);
        checkOutput("b2b drop", out_valid, 0);

        // Reset pulsed on the fourth cycle of a division discards it.
        out_ready = 1'b0;
        @(negedge clk);
        a = 8'd200; b = 8'd7; opcode = OP_DIV; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef SEQ_ALU_DIV_EN
        checkOutput("mid-div busy", out_valid, 0);
`endif
        rst = 1'b1;
        #1;
        checkOutput("mid-rst out_valid", out_valid, 0);
        checkOutput("mid-rst result", result, 0);
        checkOutput("mid-rst flags", {a_greater, a_equal, a_less}, 0);
        checkOutput("mid-rst err", err, 0);
        checkOutput("mid-rst in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("post-rst in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("post-rst no result", seen, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8, operand width in bits (minimum 2).
REQ-002 SHALL derive localparam OUT_WIDTH = 2*IN_WIDTH as the result width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1  operation request.
REQ-007 SHALL have port in_ready  out  1  block can accept a request.
REQ-008 SHALL have port a  in  IN_WIDTH  operand A (unsigned).
REQ-009 SHALL have port b  in  IN_WIDTH  operand B, or shift amount (unsigned).
REQ-010 SHALL have port opcode  in  4  operation select.
REQ-011 SHALL have port out_valid  out  1  result available.
REQ-012 SHALL have port out_ready  in  1  consumer takes the result.
REQ-013 SHALL have port result  out  OUT_WIDTH  registered result.
REQ-014 SHALL have ports a_greater, a_equal, a_less  out  1 each  registered compare flags.
REQ-015 SHALL have port err  out  1  illegal opcode or divide-by-zero.

Function
REQ-016 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1, capturing a, b and opcode.
REQ-017 SHALL decode opcodes as: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 shl, 0110 shr, 0111 mul, 1000 div, 1001 compare, 1010-1111 illegal.
REQ-018 SHALL zero-extend both operands to OUT_WIDTH; add, sub and mul SHALL wrap modulo 2^OUT_WIDTH (for example, sub 5-7 = all-ones-minus-1).
REQ-019 SHALL produce 0 for shl and shr when b >= OUT_WIDTH; shl SHALL be computed in OUT_WIDTH bits.
REQ-020 SHALL set the compare flags from a versus b for opcode 1001 only, with exactly one flag set and result = 0; for all other opcodes the flags SHALL be 0.
REQ-021 SHALL return, for illegal opcodes, result = 0, flags = 0 and err = 1; err SHALL be 0 for every other completed operation except divide-by-zero.
REQ-022 SHALL implement a three-state FSM with states IDLE, DIV and DONE.
REQ-023 SHALL transition as follows:
- IDLE, accepting a non-div op or a div with b=0 -> DONE.
- IDLE, accepting a div with b!=0 -> DIV.
- DIV -> DONE after IN_WIDTH iterations.
- DONE with out_ready=1 -> IDLE, or directly to DIV/DONE if a new request is accepted in the same cycle.
REQ-024 SHALL compute div as an iterative restoring division at one quotient bit per cycle, for IN_WIDTH cycles.
REQ-025 SHALL format the div result as result[IN_WIDTH-1:0] = quotient and result[OUT_WIDTH-1:IN_WIDTH] = remainder.
REQ-026 SHALL handle divide-by-zero with 1-cycle latency: quotient all-ones, remainder = a, err = 1.
REQ-027 SHALL assert out_valid 1 cycle after acceptance for non-div ops, and IN_WIDTH+1 cycles after acceptance for div with b!=0.
REQ-028 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-029 SHALL hold result, the flags and err stable while out_valid=1 and out_ready=0.
REQ-030 SHALL deassert out_valid on the edge where out_ready=1 and no new result completes.
REQ-031 SHALL ignore a, b and opcode changes while in DIV.

Reset
REQ-032 SHALL, while rst=1, force state to IDLE; out_valid, result, all flags and err to 0; and clear the divider registers, regardless of clock.
REQ-033 SHALL, if reset is asserted mid-division, discard the operation with no result emitted; in_ready SHALL read 1 while rst=1 and after release.

Configuration
REQ-034 SHALL, when macro SEQ_ALU_DIV_EN is defined, include the iterative divider and DIV state as specified above.
REQ-035 SHALL, when SEQ_ALU_DIV_EN is undefined, omit the divider logic and DIV state, and treat opcode 1000 as illegal (result 0, err = 1, 1-cycle latency).

Verification (IN_WIDTH=8)
REQ-036 SHALL cover add: a=200, b=100, op 0000 -> result 0x012C, out_valid 1 cycle after accept, err=0.
REQ-037 SHALL cover sub wrap and shift overflow: sub 5-7 -> 0xFFFE; shl a=0x81, b=4 -> 0x0810; shl b=16 -> 0x0000.
REQ-038 SHALL cover div: 200/7 -> result 0x041C, out_valid exactly 9 cycles after accept; 13/0 -> 0x0DFF with err=1 after 1 cycle.
REQ-039 SHALL cover backpressure and back-to-back: compare a=3, b=3 with out_ready=0 for 5 cycles -> a_equal=1 held stable, in_ready=0; then out_ready=1 with a new add accepted in the same cycle -> next result 1 cycle later.
REQ-040 SHALL cover illegal opcode and reset: op 1011 -> result 0, err=1; rst pulsed at the 4th cycle of a div -> all outputs 0 and no out_valid for that operation.
REQ-041 SHALL cover the config: with SEQ_ALU_DIV_EN undefined, op 1000 with a=200, b=7 -> result 0, err=1 after 1 cycle.
